// File: rtl/nanov_store_pkg.sv
// rtl/nanov_store_pkg.sv - shared widths and decode helpers for nanoV store capture
package nanov_store_pkg;

    localparam int WORD_W   = 32;
    localparam int ADDR_LSB = 2;
    localparam int IDX_W    = 4;

    function automatic logic [WORD_W-1:0] bit_reverse32(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) begin
            r[i] = w[WORD_W-1-i];
        end
        return r;
    endfunction

    // Returns {hit, idx}; only word-aligned addresses inside the bank decode.
    function automatic logic [IDX_W:0] ch_hit(input logic [WORD_W-1:0] addr,
                                              input logic [WORD_W-1:0] base,
                                              input int unsigned       n);
        logic [WORD_W-1:0] off;
        logic              hit;
        off = addr - base;
        hit = (addr[ADDR_LSB-1:0] == '0) && (addr >= base) && (off < (n << ADDR_LSB));
        return {hit, off[ADDR_LSB +: IDX_W]};
    endfunction

endpackage

// File: rtl/nanov_sync_fifo.sv
// rtl/nanov_sync_fifo.sv - synchronous FIFO with a registered head entry
module nanov_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [WIDTH-1:0] head_n;
    logic             push_eff, pop_eff;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);
    assign rd_nxt   = rd_ptr + PTR_W'(1);

    // The head register tracks whatever will sit at rd_ptr after this edge.
    always_comb begin
        head_n = head;
        if (pop_eff) begin
            if (count == CNT_W'(1)) begin
                if (push_eff) head_n = wdata;
            end else begin
                head_n = mem[rd_nxt];
            end
        end else if (empty && push_eff) begin
            head_n = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push_eff) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_eff)  rd_ptr <= rd_nxt;
            count <= count + CNT_W'(push_eff) - CNT_W'(pop_eff);
            head  <= head_n;
        end
    end

endmodule

// File: rtl/nanov_store_capture.sv
// rtl/nanov_store_capture.sv - nanoV store capture; optional readback via STORE_CAPTURE_READBACK_EN
module nanov_store_capture
    import nanov_store_pkg::*;
#(
    parameter int              NUM_CH       = 4,
    parameter int              DEPTH        = 8,
    parameter logic [31:0]     BASE_ADDR    = 32'h0000_1000,
    parameter int              REVERSE_DATA = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WORD_W-1:0]            data_out,
    input  logic                         store_addr_out,
    input  logic                         store_data_out,
    output logic [WORD_W*NUM_CH-1:0]     ch_data,
    output logic [NUM_CH-1:0]            ch_wr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_addr,
    output logic [WORD_W-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         ovf_clr,
    input  logic [WORD_W-1:0]            rd_addr,
    output logic [WORD_W-1:0]            rd_data
);

    logic [WORD_W-1:0]   addr_q;
    logic [WORD_W-1:0]   ch_q [NUM_CH];
    logic [WORD_W-1:0]   word;
    logic [IDX_W:0]      wr_dec;
    logic                wr_hit;
    logic [IDX_W-1:0]    wr_idx;
    logic                fifo_full, fifo_empty;
    logic [2*WORD_W-1:0] fifo_head;

    assign word   = (REVERSE_DATA != 0) ? bit_reverse32(data_out) : data_out;
    assign wr_dec = ch_hit(addr_q, BASE_ADDR, NUM_CH);
    assign wr_hit = wr_dec[IDX_W];
    assign wr_idx = wr_dec[IDX_W-1:0];

    nanov_sync_fifo #(
        .WIDTH (2*WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (store_data_out),
        .wdata ({addr_q, word}),
        .pop   (out_ready),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count),
        .head  (fifo_head)
    );

    assign out_valid = ~fifo_empty;
    assign out_addr  = fifo_head[2*WORD_W-1:WORD_W];
    assign out_data  = fifo_head[WORD_W-1:0];

    // A data strobe always consumes the old addr_q, so it masks a simultaneous address strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            ch_wr    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) ch_q[i] <= '0;
        end else begin
            ch_wr <= '0;
            if (store_data_out) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_hit && (wr_idx == IDX_W'(i))) begin
                        ch_q[i]  <= word;
                        ch_wr[i] <= 1'b1;
                    end
                end
            end else if (store_addr_out) begin
                addr_q <= data_out;
            end
            if (store_data_out && fifo_full && !(out_valid && out_ready)) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_flat
        assign ch_data[g*WORD_W +: WORD_W] = ch_q[g];
    end

`ifdef STORE_CAPTURE_READBACK_EN
    logic [IDX_W:0]    rd_dec;
    logic [WORD_W-1:0] rd_sel;

    assign rd_dec = ch_hit(rd_addr, BASE_ADDR, NUM_CH);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_dec[IDX_W-1:0] == IDX_W'(i)) rd_sel = ch_q[i];
        end
    end

    // Undo the capture reversal so the CPU sees its own bit order.
    assign rd_data = !rd_dec[IDX_W]     ? '0 :
                     (REVERSE_DATA != 0) ? bit_reverse32(rd_sel) : rd_sel;
`else
    logic rd_addr_unused;
    assign rd_addr_unused = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_nanov_store_capture.sv
// tb/tb_nanov_store_capture.sv - self-checking bench for nanov_store_capture
module tb_nanov_store_capture;

    localparam int          NUM_CH = 4;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          CW     = $clog2(DEPTH + 1);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [31:0]           data_out = '0;
    logic                  store_addr_out = 1'b0, store_data_out = 1'b0;
    logic [32*NUM_CH-1:0]  ch_data;
    logic [NUM_CH-1:0]     ch_wr;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [31:0]           out_addr, out_data;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  ovf_clr = 1'b0;
    logic [31:0]           rd_addr = '0;
    logic [31:0]           rd_data;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [31:0]       m_addr;
    logic [31:0]       m_ch [NUM_CH];
    logic [NUM_CH-1:0] m_wr;
    logic [63:0]       m_q [$];
    logic              m_ovf;

    nanov_store_capture #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .BASE_ADDR(BASE), .REVERSE_DATA(1)
    ) dut (
        .clk(clk), .rst(rst), .data_out(data_out),
        .store_addr_out(store_addr_out), .store_data_out(store_data_out),
        .ch_data(ch_data), .ch_wr(ch_wr), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .count(count), .overflow(overflow),
        .ovf_clr(ovf_clr), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rev(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = w[i];
        return r;
    endfunction

    function automatic bit m_hit(input logic [31:0] a, output int idx);
        longint off;
        off = longint'(a) - longint'(BASE);
        idx = int'(off / 4);
        return (a % 4 == 0) && (off >= 0) && (off < 4 * NUM_CH);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_addr = '0;
        m_wr   = '0;
        m_ovf  = 1'b0;
        m_q.delete();
        for (int i = 0; i < NUM_CH; i++) m_ch[i] = '0;
    endtask

    task automatic model_update();
        bit          pop, was_full, drop;
        int          idx;
        logic [31:0] w;
        pop      = (m_q.size() > 0) && out_ready;
        was_full = (m_q.size() == DEPTH);
        drop     = 1'b0;
        m_wr     = '0;
        if (pop) void'(m_q.pop_front());
        if (store_data_out) begin
            w = rev(data_out);
            if (m_hit(m_addr, idx)) begin
                m_ch[idx] = w;
                m_wr[idx] = 1'b1;
            end
            if (was_full && !pop) drop = 1'b1;
            else m_q.push_back({m_addr, w});
        end else if (store_addr_out) begin
            m_addr = data_out;
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic compare();
        int          idx;
        logic [31:0] exp_rd;
        chk("count", 64'(count), 64'(m_q.size()));
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) chk("head", {out_addr, out_data}, m_q[0]);
        for (int i = 0; i < NUM_CH; i++) chk($sformatf("ch%0d", i), 64'(ch_data[32*i +: 32]), 64'(m_ch[i]));
        chk("ch_wr", 64'(ch_wr), 64'(m_wr));
        chk("overflow", 64'(overflow), 64'(m_ovf));
`ifdef STORE_CAPTURE_READBACK_EN
        exp_rd = m_hit(rd_addr, idx) ? rev(m_ch[idx]) : 32'h0;
`else
        exp_rd = 32'h0;
`endif
        chk("rd_data", 64'(rd_data), 64'(exp_rd));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare();
    endtask

    task automatic drive(input logic sa, input logic sd, input logic [31:0] d,
                         input logic rdy, input logic clr);
        store_addr_out = sa;
        store_data_out = sd;
        data_out       = d;
        out_ready      = rdy;
        ovf_clr        = clr;
        step();
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 7))
            0, 1, 2, 3: return BASE + 32'(4 * $urandom_range(0, NUM_CH - 1));
            4:          return BASE + 32'(4 * NUM_CH);
            5:          return BASE + 32'h2;
            6:          return BASE - 32'h4;
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare();
        rst = 1'b0;

        // Hit on channel 1 with reversal
        drive(1'b1, 1'b0, 32'h0000_1004, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        chk("t2_ch1", 64'(ch_data[63:32]), 64'h1);
        chk("t2_wr", 64'(ch_wr), 64'b0010);
        chk("t2_head", {out_addr, out_data}, {32'h0000_1004, 32'h1});

        // Miss is queued but leaves channels alone
        drive(1'b1, 1'b0, 32'h0000_2000, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
        chk("t3_addr", 64'(out_addr), 64'h2000);
        chk("t3_wr", 64'(ch_wr), 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Overflow: DEPTH+1 stores without a consumer, then drain in order
        for (int i = 0; i <= DEPTH; i++) drive(1'b0, 1'b1, 32'(i), 1'b0, 1'b0);
        chk("t4_count", 64'(count), 64'(DEPTH));
        chk("t4_ovf", 64'(overflow), 64'h1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_drain", 64'(out_data), 64'(rev(32'(i))));
            drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("t4_empty", 64'(out_valid), 64'h0);

        // Full with simultaneous push and pop
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, 32'(100 + i), 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h0000_abcd, 1'b1, 1'b0);
        chk("t5_count", 64'(count), 64'(DEPTH));
        chk("t5_ovf", 64'(overflow), 64'h0);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("t5_tail", 64'(out_data), 64'(rev(32'h0000_abcd)));
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Both strobes together: data uses old address, address strobe ignored
        rd_addr = 32'h0000_1004;
        drive(1'b1, 1'b0, 32'h0000_1004, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
        chk("t6_ch1", 64'(ch_data[63:32]), 64'h1);
`ifdef STORE_CAPTURE_READBACK_EN
        chk("t6_rd", 64'(rd_data), 64'h8000_0000);
`else
        chk("t6_rd", 64'(rd_data), 64'h0);
`endif
        drive(1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0);
        chk("t6_addr_kept", 64'(ch_data[63:32]), 64'h2000_0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            logic sa, sd;
            sd = ($urandom_range(0, 99) < 45);
            sa = ($urandom_range(0, 99) < 35);
            rd_addr = pick_addr();
            drive(sa, sd, sa && !sd ? pick_addr() : $urandom,
                  ($urandom_range(0, 99) < 40), ($urandom_range(0, 99) < 5));
        end

        // Asynchronous reset mid-run
        store_data_out = 1'b1;
        store_addr_out = 1'b0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_ch", 64'(ch_data), 64'h0);
        chk("rst_head", {out_addr, out_data}, 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        chk("rst_wr", 64'(ch_wr), 64'h0);
        @(negedge clk);
        store_data_out = 1'b0;
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
